sha256_msg_padder: RTL

//  Transmit side of the SHA-256 core block interface. Accepts a message as a stream of
//  32-bit big-endian words, applies FIPS 180-4 padding (0x80, zero fill, 64-bit bit length)
//  and emits 512-bit blocks with a first-block flag on a valid/ready handshake.

---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_pad_word.sv | 26 ++
 rtl/sha256_msg_padder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: block, word and length-field widths, padder state codes, pad byte.
package sha256_pkg;

  localparam int SHA256_BLK_W       = 512;
  localparam int SHA256_WORD_W      = 32;
  localparam int SHA256_LEN_FIELD_W = 64;

  typedef logic [2:0] pad_state_t;

  localparam pad_state_t ST_FILL       = 3'd0;
  localparam pad_state_t ST_SEND       = 3'd1;
  localparam pad_state_t ST_SEND_PAD   = 3'd2;
  localparam pad_state_t ST_LEN        = 3'd3;
  localparam pad_state_t ST_SEND_FINAL = 3'd4;

  localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

endpackage

// File: rtl/sha256_pad_word.sv
// Last-word shaping: keeps the first nbytes bytes, inserts the 0x80 marker right after them
// and zeroes the rest; spill flags a full word, so the marker belongs to the next word.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] data,
  input  logic [2:0]               nbytes,
  output logic [SHA256_WORD_W-1:0] word,
  output logic                     spill
);

  logic [2:0] n;

  always_comb begin
    n     = (nbytes > 3'd4) ? 3'd4 : nbytes;
    spill = (n == 3'd4);
    word  = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < n)
        word[SHA256_WORD_W-1-8*k -: 8] = data[SHA256_WORD_W-1-8*k -: 8];
      else if (3'(k) == n)
        word[SHA256_WORD_W-1-8*k -: 8] = SHA256_PAD_BYTE;
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder feeding the SHA-256 core with 512-bit blocks.
// Optional SHA256_PAD_BLKCNT_EN adds blk_cnt_o (blocks transferred in current message).
//
// state      | meaning
// FILL       | accepting message words into the block buffer
// SEND       | full data block offered, no padding in it
// SEND_PAD   | block holding the tail/marker offered, length needs one more block
// LEN        | building the trailing length-only block
// SEND_FINAL | last block of the message (with length field) offered
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     w_v_i,
  input  logic [SHA256_WORD_W-1:0] w_data_i,
  input  logic                     w_last_i,
  input  logic [2:0]               w_nbytes_i,
  output logic                     w_ready_o,
  output logic                     blk_v_o,
  output logic [SHA256_BLK_W-1:0]  blk_o,
  output logic                     blk_new_o,
  input  logic                     blk_ready_i
`ifdef SHA256_PAD_BLKCNT_EN
  ,
  output logic [15:0]              blk_cnt_o
`endif
);

  localparam logic [SHA256_WORD_W-1:0] PAD_WORD = {SHA256_PAD_BYTE, 24'd0};

  pad_state_t                      state;
  logic [3:0]                      idx;
  logic [LEN_W-1:0]                len;
  logic                            first;
  logic                            pad_lead;
  logic [15:0][SHA256_WORD_W-1:0]  blk_q;

  logic [2:0]                      nbytes_eff;
  logic [SHA256_WORD_W-1:0]        padded;
  logic                            spill;
  logic [LEN_W-1:0]                len_next;
  logic [SHA256_LEN_FIELD_W-1:0]   len_field_next;
  logic [SHA256_LEN_FIELD_W-1:0]   len_field;
  logic                            accept;
  logic                            xfer;

  sha256_pad_word u_pad_word (
    .data   (w_data_i),
    .nbytes (nbytes_eff),
    .word   (padded),
    .spill  (spill)
  );

  assign nbytes_eff     = w_last_i ? w_nbytes_i : 3'd4;
  assign len_next       = len + LEN_W'({nbytes_eff, 3'b000});
  assign len_field_next = SHA256_LEN_FIELD_W'(len_next);
  assign len_field      = SHA256_LEN_FIELD_W'(len);

  assign w_ready_o = (state == ST_FILL);
  assign blk_v_o   = (state == ST_SEND) || (state == ST_SEND_PAD) || (state == ST_SEND_FINAL);
  assign blk_new_o = blk_v_o & first;
  assign blk_o     = blk_q;
  assign accept    = w_v_i & w_ready_o;
  assign xfer      = blk_v_o & blk_ready_i;

  // Word 0 lives in blk_q[15] so the flat buffer is already in wire order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_FILL;
      idx      <= '0;
      len      <= '0;
      first    <= 1'b1;
      pad_lead <= 1'b0;
      blk_q    <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            blk_q[4'd15 - idx] <= padded;
            len                <= len_next;
            idx                <= idx + 4'd1;
            if (!w_last_i) begin
              if (idx == 4'd15)
                state <= ST_SEND;
            end else if (!spill) begin
              if (idx <= 4'd13) begin
                {blk_q[1], blk_q[0]} <= len_field_next;
                state                <= ST_SEND_FINAL;
              end else begin
                state <= ST_SEND_PAD;
              end
            end else if (idx <= 4'd12) begin
              blk_q[4'd14 - idx]   <= PAD_WORD;
              {blk_q[1], blk_q[0]} <= len_field_next;
              state                <= ST_SEND_FINAL;
            end else if (idx <= 4'd14) begin
              blk_q[4'd14 - idx] <= PAD_WORD;
              state              <= ST_SEND_PAD;
            end else begin
              // Block ends exactly on the message; marker opens the length block.
              pad_lead <= 1'b1;
              state    <= ST_SEND_PAD;
            end
          end
        end

        ST_SEND, ST_SEND_PAD, ST_SEND_FINAL: begin
          if (blk_ready_i) begin
            blk_q <= '0;
            idx   <= '0;
            first <= 1'b0;
            case (state)
              ST_SEND:     state <= ST_FILL;
              ST_SEND_PAD: state <= ST_LEN;
              default: begin
                state <= ST_FILL;
                len   <= '0;
                first <= 1'b1;
              end
            endcase
          end
        end

        ST_LEN: begin
          blk_q[15]            <= pad_lead ? PAD_WORD : '0;
          {blk_q[1], blk_q[0]} <= len_field;
          pad_lead             <= 1'b0;
          state                <= ST_SEND_FINAL;
        end

        default: state <= ST_FILL;
      endcase
    end
  end

`ifdef SHA256_PAD_BLKCNT_EN
  logic [15:0] blk_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      blk_cnt <= '0;
    else if (xfer)
      blk_cnt <= (state == ST_SEND_FINAL) ? 16'd0 : blk_cnt + 16'd1;
  end

  assign blk_cnt_o = blk_cnt;
`endif

endmodule
